// File: rtl/mem_scanner.sv
// Sequential read-out of an 8x5 scratch RAM: walks every entry once per start
// request and publishes sum, maximum (with lowest-address tie-break) and ascending-pair count.
module mem_scanner #(
  parameter int DATA_W = 5,
  parameter int ADR_W  = 3,
  parameter int SUM_W  = 8
) (
  input  logic              clk_manual,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] rd_data_next,
  output logic [ADR_W-1:0]  rd_adr,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] max_val,
  output logic [ADR_W-1:0]  max_adr,
  output logic [ADR_W:0]    asc_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADR_W-1:0]  r_rd_adr;
  logic [SUM_W-1:0]  r_sum_acc;
  logic [DATA_W-1:0] r_max_acc;
  logic [ADR_W-1:0]  r_max_adr_acc;
  logic [ADR_W:0]    r_asc_acc;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_max_val;
  logic [ADR_W-1:0]  r_max_adr;
  logic [ADR_W:0]    r_asc_count;
  logic              r_busy;
  logic              r_done;

  logic              w_last;
  logic              w_take_max;
  logic              w_asc_inc;
  logic [SUM_W-1:0]  w_sum_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [ADR_W-1:0]  w_max_adr_nxt;
  logic [ADR_W:0]    w_asc_nxt;

  function automatic logic [SUM_W-1:0] zext_sum(input logic [DATA_W-1:0] d);
    return {{(SUM_W-DATA_W){1'b0}}, d};
  endfunction

  // Accumulator values including the entry currently presented by the RAM.
  always_comb begin
    w_last        = (r_rd_adr == {ADR_W{1'b1}});
    w_take_max    = (r_rd_adr == '0) || (rd_data > r_max_acc);
    w_asc_inc     = !w_last && (rd_data_next > rd_data);
    w_sum_nxt     = r_sum_acc + zext_sum(rd_data);
    w_max_nxt     = w_take_max ? rd_data  : r_max_acc;
    w_max_adr_nxt = w_take_max ? r_rd_adr : r_max_adr_acc;
    w_asc_nxt     = r_asc_acc + {{ADR_W{1'b0}}, w_asc_inc};
  end

  always_ff @(posedge clk_manual) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rd_adr      <= '0;
      r_sum_acc     <= '0;
      r_max_acc     <= '0;
      r_max_adr_acc <= '0;
      r_asc_acc     <= '0;
      r_sum         <= '0;
      r_max_val     <= '0;
      r_max_adr     <= '0;
      r_asc_count   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_adr <= '0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          if (start) begin
            r_sum_acc     <= '0;
            r_max_acc     <= '0;
            r_max_adr_acc <= '0;
            r_asc_acc     <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_sum_acc     <= w_sum_nxt;
          r_max_acc     <= w_max_nxt;
          r_max_adr_acc <= w_max_adr_nxt;
          r_asc_acc     <= w_asc_nxt;
          if (w_last) begin
            // Results are published only here, so no partial scan is ever visible.
            r_sum       <= w_sum_nxt;
            r_max_val   <= w_max_nxt;
            r_max_adr   <= w_max_adr_nxt;
            r_asc_count <= w_asc_nxt;
            r_done      <= 1'b1;
            r_rd_adr    <= '0;
            r_state     <= S_DONE;
          end else begin
            r_rd_adr <= r_rd_adr + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_rd_adr <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_adr    = r_rd_adr;
  assign sum       = r_sum;
  assign max_val   = r_max_val;
  assign max_adr   = r_max_adr;
  assign asc_count = r_asc_count;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_scanner.sv
// Directed bench for mem_scanner: a behavioural 8x5 RAM feeds both read ports,
// and each scenario task checks results against hand-computed values.
module tb_mem_scanner;

  logic       clk_manual;
  logic       reset_n;
  logic       start;
  logic [4:0] rd_data;
  logic [4:0] rd_data_next;
  logic [2:0] rd_adr;
  logic [7:0] sum;
  logic [4:0] max_val;
  logic [2:0] max_adr;
  logic [3:0] asc_count;
  logic       busy;
  logic       done;

  logic [4:0] mem [0:7];
  logic [2:0] w_next_adr;

  int tests;
  int fails;

  mem_scanner #(.DATA_W(5), .ADR_W(3), .SUM_W(8)) dut (
    .clk_manual  (clk_manual),
    .reset_n     (reset_n),
    .start       (start),
    .rd_data     (rd_data),
    .rd_data_next(rd_data_next),
    .rd_adr      (rd_adr),
    .sum         (sum),
    .max_val     (max_val),
    .max_adr     (max_adr),
    .asc_count   (asc_count),
    .busy        (busy),
    .done        (done)
  );

  assign w_next_adr   = rd_adr + 3'd1;
  assign rd_data      = mem[rd_adr];
  assign rd_data_next = mem[w_next_adr];

  initial clk_manual = 1'b0;
  always #5 clk_manual = ~clk_manual;

  task automatic tick();
    @(posedge clk_manual);
    #1;
  endtask

  task automatic load_mem(input logic [4:0] m0, m1, m2, m3, m4, m5, m6, m7);
    mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
    mem[4] = m4; mem[5] = m5; mem[6] = m6; mem[7] = m7;
  endtask

  // Pulses start, waits (bounded) for done, then steps one more edge back to IDLE.
  task automatic do_scan(output int lat, output int busy_cnt, output logic [2:0] seq [0:9],
                         output logic busy_after, output logic done_after);
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) seq[i] = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    seq[0] = rd_adr;
    if (busy === 1'b1) busy_cnt++;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      if (lat < 10) seq[lat] = rd_adr;
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    tick();
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    tests++;
    if ({rd_adr, sum, max_val, max_adr, asc_count, busy, done} !== 24'd0) begin
      fails++;
      $display("FAIL reset_outputs: got adr=%0d sum=%0d max=%0d madr=%0d asc=%0d busy=%b done=%b, want all 0",
               rd_adr, sum, max_val, max_adr, asc_count, busy, done);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_ramp();
    int lat, bc;
    logic [2:0] seq [0:9];
    logic ba, da;
    for (int i = 0; i < 8; i++) mem[i] = 5'(4 * i);
    do_scan(lat, bc, seq, ba, da);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL ramp_latency: got %0d, want 9", lat); end
    tests++;
    if (bc !== 9) begin fails++; $display("FAIL ramp_busy_width: got %0d, want 9", bc); end
    tests++;
    if (sum !== 8'd112) begin fails++; $display("FAIL ramp_sum: got %0d, want 112", sum); end
    tests++;
    if (max_val !== 5'd28 || max_adr !== 3'd7) begin
      fails++; $display("FAIL ramp_max: got %0d@%0d, want 28@7", max_val, max_adr);
    end
    tests++;
    if (asc_count !== 4'd7) begin fails++; $display("FAIL ramp_asc: got %0d, want 7", asc_count); end
    tests++;
    if (ba !== 1'b0 || da !== 1'b0) begin
      fails++; $display("FAIL ramp_back_to_idle: busy=%b done=%b, want 0 0", ba, da);
    end
  endtask

  task automatic test_all_max();
    int lat, bc;
    logic [2:0] seq [0:9];
    logic ba, da;
    load_mem(31, 31, 31, 31, 31, 31, 31, 31);
    do_scan(lat, bc, seq, ba, da);
    tests++;
    if (sum !== 8'd248) begin fails++; $display("FAIL allmax_sum: got %0d, want 248", sum); end
    tests++;
    if (max_val !== 5'd31 || max_adr !== 3'd0) begin
      fails++; $display("FAIL allmax_max: got %0d@%0d, want 31@0", max_val, max_adr);
    end
    tests++;
    if (asc_count !== 4'd0) begin fails++; $display("FAIL allmax_asc: got %0d, want 0", asc_count); end
    for (int k = 0; k < 9; k++) begin
      tests++;
      if (seq[k] !== ((k == 8) ? 3'd0 : 3'(k))) begin
        fails++; $display("FAIL allmax_rd_adr[%0d]: got %0d, want %0d", k, seq[k], (k == 8) ? 0 : k);
      end
    end
  endtask

  task automatic test_tie();
    int lat, bc;
    logic [2:0] seq [0:9];
    logic ba, da;
    load_mem(3, 9, 9, 1, 0, 0, 0, 0);
    do_scan(lat, bc, seq, ba, da);
    tests++;
    if (sum !== 8'd22) begin fails++; $display("FAIL tie_sum: got %0d, want 22", sum); end
    tests++;
    if (max_val !== 5'd9 || max_adr !== 3'd1) begin
      fails++; $display("FAIL tie_max: got %0d@%0d, want 9@1", max_val, max_adr);
    end
    tests++;
    if (asc_count !== 4'd1) begin fails++; $display("FAIL tie_asc: got %0d, want 1", asc_count); end
  endtask

  task automatic test_wrap();
    int lat, bc;
    logic [2:0] seq [0:9];
    logic ba, da;
    load_mem(5, 0, 0, 0, 0, 0, 0, 0);
    do_scan(lat, bc, seq, ba, da);
    tests++;
    if (asc_count !== 4'd0) begin fails++; $display("FAIL wrap_asc: got %0d, want 0", asc_count); end
    tests++;
    if (sum !== 8'd5 || max_val !== 5'd5 || max_adr !== 3'd0) begin
      fails++; $display("FAIL wrap_sum_max: got sum=%0d max=%0d@%0d, want 5 5@0", sum, max_val, max_adr);
    end
  endtask

  task automatic test_ignore_start();
    int ndone, nbusy, done_at;
    for (int i = 0; i < 8; i++) mem[i] = 5'(4 * i);
    ndone = 0; nbusy = 0; done_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy === 1'b1) nbusy++;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3 || c == 9);
      tick();
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin ndone++; done_at = c; end
    end
    start = 1'b0;
    tests++;
    if (ndone !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d, want 1", ndone); end
    tests++;
    if (done_at !== 8) begin fails++; $display("FAIL ignore_done_edge: got %0d, want 8", done_at); end
    tests++;
    if (nbusy !== 9) begin fails++; $display("FAIL ignore_busy_width: got %0d, want 9", nbusy); end
    tests++;
    if (sum !== 8'd112) begin fails++; $display("FAIL ignore_sum: got %0d, want 112", sum); end
  endtask

  task automatic test_back_to_back();
    int ndone, d1, d2;
    ndone = 0; d1 = -1; d2 = -1;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done === 1'b1) begin
        if (ndone == 0) d1 = c;
        else if (ndone == 1) d2 = c;
        ndone++;
      end
    end
    start = 1'b0;
    tests++;
    if (ndone !== 3) begin fails++; $display("FAIL b2b_done_count: got %0d, want 3", ndone); end
    tests++;
    if (d1 !== 8 || d2 !== 18) begin
      fails++; $display("FAIL b2b_done_edges: got %0d,%0d, want 8,18", d1, d2);
    end
    for (int c = 0; c < 12 && busy === 1'b1; c++) tick();
  endtask

  task automatic test_reset_mid_scan();
    int lat, bc, guard, ndone;
    logic [2:0] seq [0:9];
    logic ba, da;
    for (int i = 0; i < 8; i++) mem[i] = 5'(4 * i);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (rd_adr !== 3'd4 && guard < 20) begin tick(); guard++; end
    tests++;
    if (rd_adr !== 3'd4) begin fails++; $display("FAIL midreset_reach_adr4: got %0d, want 4", rd_adr); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tests++;
    if ({rd_adr, sum, max_val, max_adr, asc_count, busy, done} !== 24'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got adr=%0d sum=%0d max=%0d madr=%0d asc=%0d busy=%b done=%b, want all 0",
               rd_adr, sum, max_val, max_adr, asc_count, busy, done);
    end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    tests++;
    if (ndone !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d active cycles, want 0", ndone); end
    load_mem(3, 9, 9, 1, 0, 0, 0, 0);
    do_scan(lat, bc, seq, ba, da);
    tests++;
    if (lat !== 9 || sum !== 8'd22 || max_val !== 5'd9 || max_adr !== 3'd1 || asc_count !== 4'd1) begin
      fails++;
      $display("FAIL midreset_rescan: got lat=%0d sum=%0d max=%0d@%0d asc=%0d, want 9 22 9@1 1",
               lat, sum, max_val, max_adr, asc_count);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 5'd0;
    test_reset();
    test_ramp();
    test_all_max();
    test_tie();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
